// File: rtl/wire_cmd_sequencer.sv
// Host-triggered one-shot arithmetic sequencer between okWireIn and okWireOut.
// A rising edge on ctrl_wire[0] launches add/sub/shift-add mul/clear; results are held for readback.
module wire_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             okClk,
  input  logic             reset_n,
  input  logic [31:0]      ctrl_wire,
  input  logic [WIDTH-1:0] opa_wire,
  input  logic [WIDTH-1:0] opb_wire,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [31:0]      status
);

  // state | meaning
  // IDLE  | waiting for a go edge; clear completes here at the capture edge
  // EXEC  | add/sub for one cycle, mul for WIDTH shift-add cycles plus a publish cycle
  // DONE  | one-cycle cool-down after publishing; go edges here count as overrun
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b11;

  state_e             state_q, state_d;
  logic               go_prev_q, go_prev_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               ovr_q, ovr_d, carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               go_pulse;
  logic               publish;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   diff_w;
  logic [WIDTH:0]     mstep_w;
  logic               unused_ctrl;

  assign unused_ctrl = ^ctrl_wire[31:3];

  always_ff @(posedge okClk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      go_prev_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      prod_q    <= '0;
      bit_cnt_q <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= go_prev_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      bit_cnt_q <= bit_cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    go_prev_d = ctrl_wire[0];
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    prod_d    = prod_q;
    bit_cnt_d = bit_cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovr_d     = ovr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    publish   = 1'b0;

    go_pulse = ctrl_wire[0] & ~go_prev_q;
    sum_w    = {1'b0, opa_q} + {1'b0, opb_q};
    diff_w   = opa_q - opb_q;
    mstep_w  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);

    case (state_q)
      S_IDLE: begin
        if (go_pulse) begin
          opa_d = opa_wire;
          opb_d = opb_wire;
          op_d  = ctrl_wire[2:1];
          if (ctrl_wire[2:1] == OP_CLR) begin
            lo_d    = '0;
            hi_d    = '0;
            ovr_d   = 1'b0;
            carry_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            done_d    = 1'b0;
            busy_d    = 1'b1;
            prod_d    = {{WIDTH{1'b0}}, opb_wire};
            bit_cnt_d = BC_W'(WIDTH);
            state_d   = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (go_pulse) ovr_d = 1'b1;
        case (op_q)
          OP_ADD: begin
            lo_d    = sum_w[WIDTH-1:0];
            hi_d    = '0;
            carry_d = sum_w[WIDTH];
            publish = 1'b1;
          end
          OP_SUB: begin
            lo_d    = diff_w;
            hi_d    = '0;
            carry_d = (opa_q < opb_q);
            publish = 1'b1;
          end
          default: begin
            // Multiplier bits shift out of the low half as the partial product shifts in.
            if (bit_cnt_q != '0) begin
              prod_d    = {mstep_w, prod_q[WIDTH-1:1]};
              bit_cnt_d = bit_cnt_q - 1'b1;
            end else begin
              lo_d    = prod_q[WIDTH-1:0];
              hi_d    = prod_q[2*WIDTH-1:WIDTH];
              carry_d = 1'b0;
              publish = 1'b1;
            end
          end
        endcase
        // Completion flags land with the results so busy=0 always means a coherent readback.
        if (publish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (go_pulse) ovr_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result_lo = lo_q;
  assign result_hi = hi_q;

  always_comb begin
    status              = '0;
    status[0]           = busy_q;
    status[1]           = done_q;
    status[2]           = ovr_q;
    status[3]           = carry_q;
    status[8 +: CNT_W]  = cnt_q;
  end

endmodule

// File: tb/tb_wire_cmd_sequencer.sv
// Scoreboard bench for wire_cmd_sequencer: expected readback is queued at go time
// and popped when the command's fixed latency elapses.
module tb_wire_cmd_sequencer;

  logic        okClk;
  logic        reset_n;
  logic [31:0] ctrl_wire;
  logic [31:0] opa_wire, opb_wire;
  logic [31:0] result_lo, result_hi, status;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] st;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_lo, m_hi;
  logic        m_ovr, m_carry;
  int          m_cnt;

  wire_cmd_sequencer #(.WIDTH(32), .CNT_W(8)) dut (
    .okClk     (okClk),
    .reset_n   (reset_n),
    .ctrl_wire (ctrl_wire),
    .opa_wire  (opa_wire),
    .opb_wire  (opb_wire),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .status    (status)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  function automatic logic [31:0] mk_status(input logic busy, input logic done,
                                            input logic ovr, input logic carry, input int cnt);
    logic [31:0] s;
    s       = '0;
    s[0]    = busy;
    s[1]    = done;
    s[2]    = ovr;
    s[3]    = carry;
    s[15:8] = cnt[7:0];
    return s;
  endfunction

  task automatic model_reset();
    m_lo = '0; m_hi = '0; m_ovr = 1'b0; m_carry = 1'b0; m_cnt = 0;
    sb.delete();
  endtask

  // Issues one command; pulse_at>0 re-raises go mid-command, chg_a scrambles opa after capture.
  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int pulse_at, input bit chg_a, input bit drop_go, input string name);
    exp_t        e, got;
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] p_lo, p_hi;
    int          lat;
    p_lo = m_lo;
    p_hi = m_hi;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; m_lo = s[31:0]; m_hi = '0; m_carry = s[32]; end
      2'b01: begin m_lo = a - b; m_hi = '0; m_carry = (a < b); end
      2'b10: begin p = {32'b0, a} * {32'b0, b}; m_lo = p[31:0]; m_hi = p[63:32]; m_carry = 1'b0; end
      default: begin m_lo = '0; m_hi = '0; m_carry = 1'b0; m_ovr = 1'b0; end
    endcase
    if (pulse_at > 0) m_ovr = 1'b1;
    m_cnt = (m_cnt + 1) % 256;
    e.lo = m_lo;
    e.hi = m_hi;
    e.st = mk_status(1'b0, 1'b1, m_ovr, m_carry, m_cnt);
    sb.push_back(e);
    lat = (op == 2'b10) ? 34 : (op == 2'b11) ? 1 : 2;

    @(negedge okClk);
    ctrl_wire = {29'b0, op, 1'b1};
    opa_wire  = a;
    opb_wire  = b;
    for (int j = 1; j <= lat; j++) begin
      @(negedge okClk);
      if (j == lat) begin
        got = sb.pop_front();
        n_checks++;
        if (result_lo !== got.lo) begin
          n_errors++;
          $display("FAIL %s result_lo: got %h expected %h", name, result_lo, got.lo);
        end
        n_checks++;
        if (result_hi !== got.hi) begin
          n_errors++;
          $display("FAIL %s result_hi: got %h expected %h", name, result_hi, got.hi);
        end
        n_checks++;
        if (status !== got.st) begin
          n_errors++;
          $display("FAIL %s status: got %h expected %h", name, status, got.st);
        end
      end else begin
        n_checks++;
        if (status[0] !== 1'b1 || status[1] !== 1'b0 || result_lo !== p_lo || result_hi !== p_hi) begin
          n_errors++;
          $display("FAIL %s busy/hold cycle %0d: busy=%b done=%b lo=%h hi=%h expected busy=1 done=0 lo=%h hi=%h",
                   name, j, status[0], status[1], result_lo, result_hi, p_lo, p_hi);
        end
        if (chg_a && j == 1) opa_wire = ~a;
        if (pulse_at > 0 && j == pulse_at) ctrl_wire[0] = 1'b0;
        if (pulse_at > 0 && j == pulse_at + 1) ctrl_wire = 32'h0000_0001;
      end
    end
    if (drop_go) begin
      ctrl_wire[0] = 1'b0;
      @(negedge okClk);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    ctrl_wire = '0;
    opa_wire  = '0;
    opb_wire  = '0;
    model_reset();
    #12;
    n_checks++;
    if (result_lo !== 32'h0 || result_hi !== 32'h0 || status !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_state: lo=%h hi=%h st=%h expected all zero", result_lo, result_hi, status);
    end
    @(negedge okClk);
    reset_n = 1'b1;
    @(negedge okClk);
  endtask

  task automatic test_add_sub();
    issue_cmd(2'b00, 32'h0000_0005, 32'h0000_0007, 0, 1'b0, 1'b1, "add_5_7");
    issue_cmd(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0, 1'b1, "add_carry");
    issue_cmd(2'b01, 32'h0000_0003, 32'h0000_0005, 0, 1'b0, 1'b1, "sub_borrow");
    issue_cmd(2'b01, 32'h1234_5678, 32'h0000_0078, 0, 1'b0, 1'b1, "sub_plain");
  endtask

  task automatic test_mul();
    issue_cmd(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, "mul_max");
    for (int k = 0; k < 3; k++)
      issue_cmd(2'b10, $urandom, $urandom, 0, 1'b0, 1'b1, "mul_rand");
  endtask

  task automatic test_overrun_clear();
    issue_cmd(2'b10, 32'h0001_0003, 32'h0000_0101, 5, 1'b0, 1'b1, "mul_overrun");
    issue_cmd(2'b11, 32'h0, 32'h0, 0, 1'b0, 1'b1, "clear");
  endtask

  task automatic test_go_held();
    logic [31:0] exp_st;
    issue_cmd(2'b00, 32'h0000_0010, 32'h0000_0020, 0, 1'b1, 1'b0, "add_held");
    exp_st = mk_status(1'b0, 1'b1, m_ovr, m_carry, m_cnt);
    repeat (100) @(negedge okClk);
    n_checks++;
    if (status !== exp_st || result_lo !== m_lo) begin
      n_errors++;
      $display("FAIL go_held_retrigger: st=%h lo=%h expected st=%h lo=%h", status, result_lo, exp_st, m_lo);
    end
    ctrl_wire[0] = 1'b0;
    @(negedge okClk);
  endtask

  task automatic test_reset_mid_mul();
    @(negedge okClk);
    ctrl_wire = 32'h0000_0005;
    opa_wire  = 32'h0000_1234;
    opb_wire  = 32'h0000_5678;
    repeat (10) @(negedge okClk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (result_lo !== 32'h0 || result_hi !== 32'h0 || status !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset_mid_mul: lo=%h hi=%h st=%h expected all zero", result_lo, result_hi, status);
    end
    ctrl_wire = '0;
    model_reset();
    @(negedge okClk);
    reset_n = 1'b1;
    @(negedge okClk);
    issue_cmd(2'b00, 32'h0000_0100, 32'h0000_0023, 0, 1'b0, 1'b1, "add_after_reset");
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_overrun_clear();
    test_go_held();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
